// File: rtl/ffd_arb_pkg.sv
// Shared types, defaults and the round-robin winner search for the FFD bank arbiter.
package ffd_arb_pkg;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_NREG  = 4;
    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned MAX_NREQ  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Index of the first set request at or after ptr, wrapping modulo nreq.
    function automatic logic [2:0] next_rr(
        input logic [MAX_NREQ-1:0] req,
        input logic [2:0]          ptr,
        input int unsigned         nreq
    );
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        win   = 3'd0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            idx = (32'(ptr) + k) % nreq;
            if (!found && (k < nreq) && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/en_reg.sv
// WIDTH-bit enabled D register with synchronous active-high reset.
module en_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ffd_bank_arbiter.sv
// Round-robin arbiter that sequences single-cycle writes into a shared FFD register bank.
module ffd_bank_arbiter
    import ffd_arb_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned NREG  = DEF_NREG,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    addr,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [NREG*WIDTH-1:0] q
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic [AW-1:0]     laddr;
    logic [WIDTH-1:0]  ldata;

    logic [PW-1:0]     sel;
    logic [AW-1:0]     sel_addr;
    logic [WIDTH-1:0]  sel_data;
    logic [NREG-1:0]   reg_en;

    // Pick the round-robin winner and mux out its payload.
    always_comb begin
        sel      = PW'(next_rr(MAX_NREQ'(req), 3'(ptr), NREQ));
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == PW'(i)) begin
                sel_addr = addr[i*AW +: AW];
                sel_data = data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Single register enable, active only in GRANT.
    always_comb begin
        reg_en = '0;
        if (state == ST_GRANT) begin
            reg_en[laddr] = 1'b1;
        end
    end

    // Arbitration FSM, pointer and payload latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            win   <= '0;
            laddr <= '0;
            ldata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        win   <= sel;
                        laddr <= sel_addr;
                        ldata <= sel_data;
                        gnt   <= NREQ'(1) << sel;
                        busy  <= 1'b1;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The register bank itself; q is taken straight from the flops.
    for (genvar r = 0; r < NREG; r++) begin : g_bank
        en_reg #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (reg_en[r]),
            .d     (ldata),
            .q     (q[r*WIDTH +: WIDTH])
        );
    end

endmodule
